im2_scheduler: RTL and testbench
================================

IM2_SCHEDULER -- requirements
Module: im2_scheduler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): DATA_WIDTH_map, 8, cycles per im2 chunk window; CHUNK_K, 8, elements per chunk row; PACK, 4, lanes per cycle; MAX_X1, 5, kernel height max; MAX_X3, 32, input channels max; MAX_Y1, 32, map width max; MAX_Y2, 32, map height max; MAX_N, 64, output kernels max.
REQ-002 The block SHALL have these ports (name, direction, width, meaning): clk, in, 1, sole clock; rst, in, 1, synchronous active-high reset; start, in, 1, begin one layer pass; abort, in, 1, return to IDLE; X1/X2, in, $clog2(MAX_X1)+1, kernel dims; X3, in, $clog2(MAX_X3)+1, channels; Y1, in, $clog2(MAX_Y1)+1, map width; Y2, in, $clog2(MAX_Y2)+1, map height; STRIDE, in, 3, stride; N_OUT, in, 16, kernel count; OH/OW, in, 16, output rows/cols; im2_done, in, 1, im2 window finished; en_im2, out, 1, im2 enable; n, out, 16, current kernel; k_grp, out, 16, current chunk group; patch_i, out, $clog2(MAX_Y2)+1, output row; patch_j, out, $clog2(MAX_Y1)+1, output col; first_grp, out, 1, first group of a patch (accumulator clear); out_valid, out, 1, patch result ready; out_ready, in, 1, downstream accept; busy, out, 1, pass in progress; layer_done, out, 1, one-cycle completion pulse.

Function
REQ-003 States SHALL be IDLE, CALC, RUN, GAP, EMIT, FIN.
REQ-004 IDLE: on start=1 latch all config inputs and go to CALC; start SHALL be ignored outside IDLE.
REQ-005 CALC (1 cycle): compute NGRP = ceil(X1*X2*X3 / (CHUNK_K*PACK)) in a registered form; clear n, patch_i, patch_j, k_grp; if N_OUT, OH or OW is 0, go to FIN, else go to RUN.
REQ-006 RUN: en_im2=1 (registered); first_grp=1 iff k_grp==0; on im2_done=1 go to GAP.
REQ-007 GAP: en_im2=0 for exactly one cycle (this resets im2's counter); then, if k_grp<NGRP-1, increment k_grp and go to RUN, otherwise clear k_grp and go to EMIT.
REQ-008 This SHALL give a chunk period of DATA_WIDTH_map+2 cycles: en_im2 high for DATA_WIDTH_map+1 cycles, then low for 1.
REQ-009 EMIT: out_valid=1 with n/patch_i/patch_j held stable; on out_ready=1, advance the indices with patch_j innermost, then patch_i, then n. Each index wraps to 0 at OW, OH and N_OUT respectively, carrying into the next. Then go to RUN, or go to FIN once the last n/patch has been emitted.
REQ-010 out_valid SHALL be held, with payload stable, until it is accepted; valid SHALL NOT depend on ready.
REQ-011 FIN: layer_done=1 for one cycle, then go to IDLE.
REQ-012 abort=1 in any state SHALL force IDLE on the next edge with en_im2=0 and out_valid=0. abort SHALL have priority over start, im2_done and out_ready.
REQ-013 busy SHALL be 1 in every state except IDLE.
REQ-014 Index arithmetic SHALL be unsigned. Output index widths are as declared; config values beyond the MAX_* parameters are out of range and behaviour for them is undefined.

Reset
REQ-015 On rst=1 at a clock edge: state=IDLE; en_im2, out_valid, busy, layer_done and first_grp = 0; n, k_grp, patch_i, patch_j and NGRP = 0. rst has priority over abort.
REQ-016 Reset asserted mid-pass SHALL discard the pass; no layer_done is produced.

Structure
REQ-017 A shared package im2_pkg SHALL hold the state enum type and the CHUNK_K/PACK default constants used by both im2 and this block.
REQ-018 An index-advance sub-module, im2_patch_counter (nested wrap counter for j, i, n with a last flag), SHALL be instantiated once.

Verification
REQ-019 X1=X2=3, X3=1, N_OUT=1, OH=OW=1, out_ready=1 -> NGRP=1; en_im2 high 9 cycles; one out_valid; layer_done 1 cycle later.
REQ-020 X1=X2=5, X3=3 (75 elements), N_OUT=2, OH=OW=2 -> NGRP=3; 8 out_valid events in order (n,i,j) = (0,0,0),(0,0,1),(0,1,0)…(1,1,1); first_grp high once per patch.
REQ-021 Hold out_ready=0 for 5 cycles in EMIT -> out_valid and indices stable throughout, en_im2=0; progress resumes on the first ready.
REQ-022 N_OUT=0 with start -> layer_done 2 cycles after start; en_im2 never asserted.
REQ-023 abort at the 4th cycle of RUN -> IDLE next cycle, en_im2=0; a new start gives a clean pass from n=0.
REQ-024 rst asserted during EMIT, then start -> all outputs 0 during reset; the full pass repeats correctly.

Source files
------------

// File: rtl/im2_pkg.sv
// Shared definitions for the im2 datapath and its layer scheduler.
package im2_pkg;

  // Default chunk geometry: elements per chunk row and lanes per cycle.
  localparam int unsigned CHUNK_K_DEF = 8;
  localparam int unsigned PACK_DEF    = 4;

  // Scheduler state encoding.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_RUN  = 3'd2,
    ST_GAP  = 3'd3,
    ST_EMIT = 3'd4,
    ST_FIN  = 3'd5
  } sched_state_e;

  // Number of chunk groups needed to cover 'elems' elements, rounded up.
  function automatic logic [15:0] ceil_groups(input logic [31:0] elems,
                                              input logic [31:0] grp);
    logic [31:0] q;
    q = (elems + grp - 32'd1) / grp;
    return q[15:0];
  endfunction

endpackage

// File: rtl/im2_patch_counter.sv
// Nested wrap counter walking output patches: j innermost, then i, then n.
// 'last' flags the final (n, i, j) position so the scheduler can finish.
module im2_patch_counter #(
  parameter int JW = 6,
  parameter int IW = 6,
  parameter int NW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  input  logic [15:0]   lim_j,
  input  logic [15:0]   lim_i,
  input  logic [15:0]   lim_n,
  output logic [JW-1:0] j,
  output logic [IW-1:0] i,
  output logic [NW-1:0] n,
  output logic          last
);

  logic [JW-1:0] j_q, j_d;
  logic [IW-1:0] i_q, i_d;
  logic [NW-1:0] n_q, n_d;
  logic          wrap_j, wrap_i, wrap_n;

  // Each index is at its final value when index+1 reaches its limit; the
  // compare is widened so a limit of 0xFFFF cannot overflow.
  always_comb begin
    wrap_j = (17'(j_q) + 17'd1) >= 17'(lim_j);
    wrap_i = (17'(i_q) + 17'd1) >= 17'(lim_i);
    wrap_n = (17'(n_q) + 17'd1) >= 17'(lim_n);
  end

  // Next-index computation with carry from j into i into n.
  always_comb begin
    j_d = j_q;
    i_d = i_q;
    n_d = n_q;
    if (clr) begin
      j_d = '0;
      i_d = '0;
      n_d = '0;
    end else if (adv) begin
      if (!wrap_j) begin
        j_d = j_q + JW'(1);
      end else begin
        j_d = '0;
        if (!wrap_i) begin
          i_d = i_q + IW'(1);
        end else begin
          i_d = '0;
          if (!wrap_n) begin
            n_d = n_q + NW'(1);
          end else begin
            n_d = '0;
          end
        end
      end
    end
  end

  // Index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      j_q <= '0;
      i_q <= '0;
      n_q <= '0;
    end else begin
      j_q <= j_d;
      i_q <= i_d;
      n_q <= n_d;
    end
  end

  assign j    = j_q;
  assign i    = i_q;
  assign n    = n_q;
  assign last = wrap_j & wrap_i & wrap_n;

endmodule

// File: rtl/im2_scheduler.sv
// Layer scheduler for the im2 engine: sequences chunk groups per output
// patch, hands each finished patch downstream, and walks all kernels.
module im2_scheduler
  import im2_pkg::*;
#(
  parameter int DATA_WIDTH_map = 8,
  parameter int CHUNK_K        = CHUNK_K_DEF,
  parameter int PACK           = PACK_DEF,
  parameter int MAX_X1         = 5,
  parameter int MAX_X3         = 32,
  parameter int MAX_Y1         = 32,
  parameter int MAX_Y2         = 32,
  parameter int MAX_N          = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [$clog2(MAX_X1):0]     X1,
  input  logic [$clog2(MAX_X1):0]     X2,
  input  logic [$clog2(MAX_X3):0]     X3,
  input  logic [$clog2(MAX_Y1):0]     Y1,
  input  logic [$clog2(MAX_Y2):0]     Y2,
  input  logic [2:0]                  STRIDE,
  input  logic [15:0]                 N_OUT,
  input  logic [15:0]                 OH,
  input  logic [15:0]                 OW,
  input  logic                        im2_done,
  output logic                        en_im2,
  output logic [15:0]                 n,
  output logic [15:0]                 k_grp,
  output logic [$clog2(MAX_Y2):0]     patch_i,
  output logic [$clog2(MAX_Y1):0]     patch_j,
  output logic                        first_grp,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        layer_done
);

  localparam int XW  = $clog2(MAX_X1) + 1;
  localparam int X3W = $clog2(MAX_X3) + 1;
  localparam int Y1W = $clog2(MAX_Y1) + 1;
  localparam int Y2W = $clog2(MAX_Y2) + 1;
  localparam logic [31:0] GRP_ELEMS = 32'(CHUNK_K * PACK);

  // Window length is set by the im2 engine itself and the kernel limit only
  // bounds the caller's N_OUT; neither changes this block's logic.
  localparam int unused_params = DATA_WIDTH_map + MAX_N;

  sched_state_e state_q, state_d;

  logic [XW-1:0]  x1_q, x1_d, x2_q, x2_d;
  logic [X3W-1:0] x3_q, x3_d;
  logic [Y1W-1:0] y1_q, y1_d;
  logic [Y2W-1:0] y2_q, y2_d;
  logic [2:0]     stride_q, stride_d;
  logic [15:0]    n_out_q, n_out_d, oh_q, oh_d, ow_q, ow_d;
  logic [15:0]    ngrp_q, ngrp_d;
  logic [15:0]    k_grp_q, k_grp_d;
  logic           en_im2_q, en_im2_d;
  logic           out_valid_q, out_valid_d;
  logic           busy_q, busy_d;
  logic           layer_done_q, layer_done_d;
  logic           first_grp_q, first_grp_d;
  logic [31:0]    elems;
  logic           cnt_clr, cnt_adv, cnt_last;

  // Map geometry and stride are latched with the pass but consumed by im2.
  logic unused_cfg;
  assign unused_cfg = ^{y1_q, y2_q, stride_q};

  im2_patch_counter #(
    .JW (Y1W),
    .IW (Y2W),
    .NW (16)
  ) u_patch_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .adv   (cnt_adv),
    .lim_j (ow_q),
    .lim_i (oh_q),
    .lim_n (n_out_q),
    .j     (patch_j),
    .i     (patch_i),
    .n     (n),
    .last  (cnt_last)
  );

  // Next-state, config capture, group counting and registered-output decode.
  always_comb begin
    state_d  = state_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    x3_d     = x3_q;
    y1_d     = y1_q;
    y2_d     = y2_q;
    stride_d = stride_q;
    n_out_d  = n_out_q;
    oh_d     = oh_q;
    ow_d     = ow_q;
    ngrp_d   = ngrp_q;
    k_grp_d  = k_grp_q;
    cnt_clr  = 1'b0;
    cnt_adv  = 1'b0;
    elems    = 32'(x1_q) * 32'(x2_q) * 32'(x3_q);

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            x1_d     = X1;
            x2_d     = X2;
            x3_d     = X3;
            y1_d     = Y1;
            y2_d     = Y2;
            stride_d = STRIDE;
            n_out_d  = N_OUT;
            oh_d     = OH;
            ow_d     = OW;
            state_d  = ST_CALC;
          end
        end
        ST_CALC: begin
          ngrp_d  = ceil_groups(elems, GRP_ELEMS);
          k_grp_d = '0;
          cnt_clr = 1'b1;
          if ((n_out_q == '0) || (oh_q == '0) || (ow_q == '0)) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (im2_done) begin
            state_d = ST_GAP;
          end
        end
        ST_GAP: begin
          // Compare k_grp+1 against NGRP so an empty kernel still acts as one group.
          if ((17'(k_grp_q) + 17'd1) < 17'(ngrp_q)) begin
            k_grp_d = k_grp_q + 16'd1;
            state_d = ST_RUN;
          end else begin
            k_grp_d = '0;
            state_d = ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            cnt_adv = 1'b1;
            state_d = cnt_last ? ST_FIN : ST_RUN;
          end
        end
        ST_FIN: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    en_im2_d     = (state_d == ST_RUN);
    out_valid_d  = (state_d == ST_EMIT);
    busy_d       = (state_d != ST_IDLE);
    layer_done_d = (state_d == ST_FIN);
    first_grp_d  = (state_d == ST_RUN) && (k_grp_d == '0);
  end

  // State, configuration and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      x1_q         <= '0;
      x2_q         <= '0;
      x3_q         <= '0;
      y1_q         <= '0;
      y2_q         <= '0;
      stride_q     <= '0;
      n_out_q      <= '0;
      oh_q         <= '0;
      ow_q         <= '0;
      ngrp_q       <= '0;
      k_grp_q      <= '0;
      en_im2_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      layer_done_q <= 1'b0;
      first_grp_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      x1_q         <= x1_d;
      x2_q         <= x2_d;
      x3_q         <= x3_d;
      y1_q         <= y1_d;
      y2_q         <= y2_d;
      stride_q     <= stride_d;
      n_out_q      <= n_out_d;
      oh_q         <= oh_d;
      ow_q         <= ow_d;
      ngrp_q       <= ngrp_d;
      k_grp_q      <= k_grp_d;
      en_im2_q     <= en_im2_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      layer_done_q <= layer_done_d;
      first_grp_q  <= first_grp_d;
    end
  end

  assign en_im2     = en_im2_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign layer_done = layer_done_q;
  assign first_grp  = first_grp_q;
  assign k_grp      = k_grp_q;

endmodule

// File: tb/tb_im2_scheduler.sv
// Self-checking bench for im2_scheduler with a behavioural im2 window model.
module tb_im2_scheduler;

  localparam int DW = 8;

  logic        clk = 1'b0;
  logic        rst, start, abort, out_ready;
  logic [3:0]  X1, X2;
  logic [5:0]  X3, Y1, Y2;
  logic [2:0]  STRIDE;
  logic [15:0] N_OUT, OH, OW;
  logic        im2_done = 1'b0;
  logic        en_im2, first_grp, out_valid, busy, layer_done;
  logic [15:0] n, k_grp;
  logic [5:0]  patch_i, patch_j;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  im2_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .X1(X1), .X2(X2), .X3(X3), .Y1(Y1), .Y2(Y2), .STRIDE(STRIDE),
    .N_OUT(N_OUT), .OH(OH), .OW(OW), .im2_done(im2_done),
    .en_im2(en_im2), .n(n), .k_grp(k_grp), .patch_i(patch_i), .patch_j(patch_j),
    .first_grp(first_grp), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .layer_done(layer_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // im2 engine model: finishes its window after DW+1 enabled cycles.
  int im2_cnt = 0;
  always @(negedge clk) begin
    if (rst || !en_im2) begin
      im2_cnt = 0;
      im2_done = 1'b0;
    end else begin
      im2_cnt = im2_cnt + 1;
      im2_done = (im2_cnt == DW + 1);
    end
  end

  // Observation monitor: collects enable runs, accepts and pulses.
  int          run_len, valid_cyc, fg_rises, ld_cnt, ld_cyc, last_acc_cyc;
  int          stab_err, overlap_err;
  int          runs_q[$];
  int          kst_q[$];
  logic [31:0] acc_q[$];
  logic        prev_en = 1'b0, prev_fg = 1'b0, prev_valid = 1'b0, prev_acc = 1'b0;
  logic [31:0] prev_pay = '0, mon_pay;

  always @(negedge clk) begin
    if (en_im2) run_len = run_len + 1;
    else if (run_len > 0) begin
      runs_q.push_back(run_len);
      run_len = 0;
    end
    if (en_im2 && !prev_en) kst_q.push_back(int'(k_grp));
    if (first_grp && !prev_fg) fg_rises = fg_rises + 1;
    mon_pay = {n, 2'b00, patch_i, 2'b00, patch_j};
    if (out_valid) begin
      valid_cyc = valid_cyc + 1;
      if (prev_valid && !prev_acc && mon_pay !== prev_pay) stab_err = stab_err + 1;
      if (out_ready) begin
        acc_q.push_back(mon_pay);
        last_acc_cyc = cyc;
      end
    end
    if (en_im2 && out_valid) overlap_err = overlap_err + 1;
    if (layer_done) begin
      ld_cnt = ld_cnt + 1;
      ld_cyc = cyc;
    end
    prev_en    = en_im2;
    prev_fg    = first_grp;
    prev_valid = out_valid;
    prev_acc   = out_valid && out_ready;
    prev_pay   = mon_pay;
  end

  task automatic clear_mon();
    run_len = 0; valid_cyc = 0; fg_rises = 0; ld_cnt = 0; ld_cyc = -1;
    last_acc_cyc = -100; stab_err = 0; overlap_err = 0;
    runs_q.delete(); kst_q.delete(); acc_q.delete();
  endtask

  task automatic drive_cfg(input int x1, input int x2, input int x3,
                           input int nout, input int oh, input int ow);
    X1 = 4'(x1); X2 = 4'(x2); X3 = 6'(x3);
    Y1 = 6'($urandom_range(1, 32)); Y2 = 6'($urandom_range(1, 32));
    STRIDE = 3'($urandom_range(1, 4));
    N_OUT = 16'(nout); OH = 16'(oh); OW = 16'(ow);
  endtask

  // One full layer pass, checked against the expected schedule.
  // mode 0: always ready; 1: random ready plus stray starts; 2: 5-cycle stall on first patch.
  task automatic run_pass(input int x1, input int x2, input int x3, input int nout,
                          input int oh, input int ow, input int mode, input string tag);
    int ngrp, patches, budget, stalls, bad;
    bit done;
    logic [31:0] exp_q[$];
    ngrp    = (x1 * x2 * x3 + 31) / 32;
    patches = nout * oh * ow;
    for (int nn = 0; nn < nout; nn++)
      for (int ii = 0; ii < oh; ii++)
        for (int jj = 0; jj < ow; jj++)
          exp_q.push_back({16'(nn), 2'b00, 6'(ii), 2'b00, 6'(jj)});

    @(posedge clk); #1;
    clear_mon();
    drive_cfg(x1, x2, x3, nout, oh, ow);
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    budget = 100 + patches * (ngrp * 12 + 20);
    done = 0;
    stalls = 0;
    for (int c = 0; c < budget && !done; c++) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (out_valid && stalls < 5) begin
            out_ready = 1'b0;
            stalls++;
          end else out_ready = 1'b1;
        end
      endcase
      if (mode == 1 && busy && !layer_done && $urandom_range(0, 15) == 0) begin
        drive_cfg($urandom_range(1, 5), $urandom_range(1, 5), $urandom_range(1, 8),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (ld_cnt > 0) done = 1;
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    checks++;
    if (!done) begin failures++; $display("FAIL %s timeout: layer_done not seen within %0d cycles", tag, budget); end
    checks++;
    if (runs_q.size() !== ngrp * patches) begin
      failures++; $display("FAIL %s en_runs: got %0d expected %0d", tag, runs_q.size(), ngrp * patches);
    end
    bad = 0;
    foreach (runs_q[r]) if (runs_q[r] != DW + 1) bad++;
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL %s en_run_len: %0d runs not %0d cycles long", tag, bad, DW + 1); end
    bad = 0;
    foreach (kst_q[r]) if (kst_q[r] != r % ngrp) bad++;
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL %s k_grp_seq: %0d runs with wrong k_grp (ngrp %0d)", tag, bad, ngrp); end
    checks++;
    if (acc_q.size() !== patches) begin
      failures++; $display("FAIL %s accepts: got %0d expected %0d", tag, acc_q.size(), patches);
    end
    bad = 0;
    for (int k = 0; k < patches && k < acc_q.size(); k++) if (acc_q[k] !== exp_q[k]) bad++;
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL %s order: %0d accepts with wrong (n,i,j), first got %h", tag, bad, acc_q.size() > 0 ? acc_q[0] : 32'h0); end
    checks++;
    if (fg_rises !== patches) begin failures++; $display("FAIL %s first_grp: got %0d rises expected %0d", tag, fg_rises, patches); end
    checks++;
    if (ld_cnt !== 1) begin failures++; $display("FAIL %s layer_done_len: got %0d cycles expected 1", tag, ld_cnt); end
    checks++;
    if (ld_cyc !== last_acc_cyc + 1) begin failures++; $display("FAIL %s layer_done_time: got cycle %0d expected %0d", tag, ld_cyc, last_acc_cyc + 1); end
    checks++;
    if (stab_err !== 0) begin failures++; $display("FAIL %s stability: got %0d payload changes expected 0", tag, stab_err); end
    checks++;
    if (overlap_err !== 0) begin failures++; $display("FAIL %s en_during_emit: got %0d cycles expected 0", tag, overlap_err); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_after: got %b expected 0", tag, busy); end
    if (mode != 1) begin
      checks++;
      if (valid_cyc !== patches + (mode == 2 ? 5 : 0)) begin
        failures++; $display("FAIL %s valid_cycles: got %0d expected %0d", tag, valid_cyc, patches + (mode == 2 ? 5 : 0));
      end
    end
    $display("pass %s cfg=%0dx%0dx%0d n=%0d oh=%0d ow=%0d ngrp=%0d accepted=%0d", tag, x1, x2, x3, nout, oh, ow, ngrp, acc_q.size());
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({en_im2, out_valid, busy, layer_done, first_grp} !== 5'b0) begin
      failures++; $display("FAIL %s ctrl_outputs: got %b expected 00000", tag, {en_im2, out_valid, busy, layer_done, first_grp});
    end
    checks++;
    if ({n, k_grp, patch_i, patch_j} !== 44'b0) begin
      failures++; $display("FAIL %s index_outputs: got n=%0d k=%0d i=%0d j=%0d expected all 0", tag, n, k_grp, patch_i, patch_j);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    drive_cfg(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_zero_dims();
    int s;
    for (int v = 0; v < 3; v++) begin
      @(posedge clk); #1;
      clear_mon();
      drive_cfg(3, 3, 1, v == 0 ? 0 : 2, v == 1 ? 0 : 2, v == 2 ? 0 : 2);
      s = cyc;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL zero%0d busy_calc: got %b expected 1", v, busy); end
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (ld_cyc !== s + 2) begin failures++; $display("FAIL zero%0d layer_done_time: got cycle %0d expected %0d", v, ld_cyc, s + 2); end
      checks++;
      if (ld_cnt !== 1) begin failures++; $display("FAIL zero%0d layer_done_len: got %0d expected 1", v, ld_cnt); end
      checks++;
      if (runs_q.size() + run_len + valid_cyc !== 0) begin
        failures++; $display("FAIL zero%0d activity: got %0d en runs %0d valid cycles expected none", v, runs_q.size(), valid_cyc);
      end
      $display("zero-dim pass %0d start=%0d layer_done=%0d", v, s, ld_cyc);
    end
  endtask

  task automatic test_abort();
    int hi;
    bit hit;
    @(posedge clk); #1;
    clear_mon();
    drive_cfg(5, 5, 3, 2, 2, 2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hi = 0; hit = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      if (en_im2) hi++;
      if (hi == 4) begin
        abort = 1'b1;
        hit = 1;
      end
      @(posedge clk); #1;
    end
    abort = 1'b0;
    checks++;
    if (!hit) begin failures++; $display("FAIL abort timeout: RUN not reached"); end
    checks++;
    if ({en_im2, out_valid, busy, layer_done} !== 4'b0) begin
      failures++; $display("FAIL abort outputs: got en/valid/busy/done=%b expected 0000", {en_im2, out_valid, busy, layer_done});
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (ld_cnt !== 0) begin failures++; $display("FAIL abort no_done: got %0d layer_done cycles expected 0", ld_cnt); end
    $display("abort issued on RUN cycle %0d", hi);
    run_pass(3, 3, 2, 2, 1, 2, 0, "after_abort");
  endtask

  task automatic test_reset_mid_pass();
    bit hit;
    @(posedge clk); #1;
    clear_mon();
    drive_cfg(3, 3, 1, 2, 2, 2);
    out_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (out_valid) hit = 1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL rst_mid timeout: EMIT not reached"); end
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_all_zero("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (ld_cnt !== 0) begin failures++; $display("FAIL rst_mid no_done: got %0d layer_done cycles expected 0", ld_cnt); end
    $display("reset applied during EMIT");
    run_pass(3, 3, 1, 2, 2, 2, 0, "after_rst");
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      run_pass($urandom_range(1, 5), $urandom_range(1, 5), $urandom_range(1, 8),
               $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3), 1,
               $sformatf("rand%0d", t));
    end
  endtask

  initial begin
    test_reset();
    run_pass(3, 3, 1, 1, 1, 1, 0, "single");
    run_pass(5, 5, 3, 2, 2, 2, 0, "order");
    run_pass(5, 5, 3, 2, 2, 2, 2, "backpressure");
    test_zero_dims();
    test_abort();
    test_reset_mid_pass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
